dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares the single-port, synchronous-read data memory between two requesters: port 0 is the core load/store unit, port 1 is a debug/loader master. It grants at most one access per cycle and drives the memory's address, write-data and write-enable inputs. It returns read data one cycle after the grant, tagged to the requester that issued the read. It sits between the core datapath and the data memory, whose address, write-data, write-enable and read-data pins connect directly to the `mem_*` ports.

---
 rtl/dmem_arbiter.sv | 110 +++++++++++
 tb/tb_dmem_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port, synchronous-read data memory between
// port 0 (core load/store unit) and port 1 (debug/loader master).
// At most one access is granted per cycle. Read data returns one cycle after
// the grant, steered to the port that issued the read.
// Build option: define DMEM_ARB_FIXED_PRIO_EN to make port 0 always win ties.
// In that build the round-robin pointer does not exist.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_WD,
  output logic              mem_WE,
  input  logic [DATA_W-1:0] mem_RD
);

  logic rd_pend_q, rd_pend_d;
  logic rd_owner_q, rd_owner_d;
  logic p0_wins_tie;
  logic gnt_any;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // Fixed priority: port 0 wins every tie.
  assign p0_wins_tie = 1'b1;
`else
  logic last_q, last_d;

  // Round-robin: port 0 wins a tie only when port 1 was granted most recently.
  assign p0_wins_tie = last_q;

  // Pointer follows the granted port. Idle cycles leave it unchanged.
  always_comb begin
    last_d = last_q;
    if (gnt_any) last_d = m1_gnt;
  end

  // Pointer register. The reset value of 1 lets port 0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`endif

  // Grant decode. Grants are gated by rst_n, so no access leaks out while
  // reset is held, even if the requests are still asserted.
  assign m0_gnt  = rst_n & m0_req & (~m1_req | p0_wins_tie);
  assign m1_gnt  = rst_n & m1_req & (~m0_req | ~p0_wins_tie);
  assign gnt_any = m0_gnt | m1_gnt;

  // Memory drive mux. Every output is forced to zero when there is no grant.
  always_comb begin
    // NOTE: every output gets a default first so that no path infers a latch.
    mem_A  = '0;
    mem_WD = '0;
    mem_WE = 1'b0;
    if (m0_gnt) begin
      mem_A  = m0_addr;
      mem_WD = m0_wdata;
      mem_WE = m0_we;
    end else if (m1_gnt) begin
      mem_A  = m1_addr;
      mem_WD = m1_wdata;
      mem_WE = m1_we;
    end
  end

  // Read tracking. Each granted read opens a one-cycle response slot for its owner.
  always_comb begin
    rd_pend_d  = gnt_any & ~mem_WE;
    rd_owner_d = rd_owner_q;
    if (gnt_any) rd_owner_d = m1_gnt;
  end

  // Read-response registers. Reset drops any read that is still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, to avoid
    // ordering races between flops.
    if (!rst_n) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Response steering. Memory read data goes to the owning port only.
  // The other port sees zeros.
  assign m0_rvalid = rd_pend_q & ~rd_owner_q;
  assign m1_rvalid = rd_pend_q &  rd_owner_q;
  assign m0_rdata  = m0_rvalid ? mem_RD : '0;
  assign m1_rdata  = m1_rvalid ? mem_RD : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter. A small synchronous-read memory model sits
// on the mem_* pins. Inputs change on the falling edge, and outputs are
// compared 1 ns later, well away from the rising edge.
module tb_dmem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              m0_req = 1'b0, m0_we = 1'b0;
  logic [ADDR_W-1:0] m0_addr = '0;
  logic [DATA_W-1:0] m0_wdata = '0;
  logic              m0_gnt, m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;
  logic              m1_req = 1'b0, m1_we = 1'b0;
  logic [ADDR_W-1:0] m1_addr = '0;
  logic [DATA_W-1:0] m1_wdata = '0;
  logic              m1_gnt, m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;
  logic [ADDR_W-1:0] mem_A;
  logic [DATA_W-1:0] mem_WD;
  logic              mem_WE;
  logic [DATA_W-1:0] mem_RD = '0;

  logic [DATA_W-1:0] mem [16];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
  );

  // Memory model. Contents are preloaded while reset is held. Reads are
  // registered, and a write updates the array on its own edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[1] <= 32'h11; mem[2] <= 32'h22; mem[3] <= 32'h33;
      mem[4] <= 32'h44; mem[5] <= 32'h55;
    end else begin
      if (mem_WE) mem[mem_A[3:0]] <= mem_WD;
      mem_RD <= mem[mem_A[3:0]];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic drive(input logic r0, input logic w0, input int a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input int a1, input logic [31:0] d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    #1;
  endtask

  task automatic chk_rsp(input string tag, input logic v0, input logic [31:0] d0,
                         input logic v1, input logic [31:0] d1);
    check({tag, ".m0_rvalid"}, m0_rvalid, v0);
    check({tag, ".m0_rdata"},  m0_rdata,  d0);
    check({tag, ".m1_rvalid"}, m1_rvalid, v1);
    check({tag, ".m1_rdata"},  m1_rdata,  d1);
  endtask

  initial begin
    // Reset is held with both ports requesting. Nothing may be granted.
    drive(1, 0, 1, 0, 1, 0, 2, 0);
    repeat (3) next_cycle();
    #1;
    check("rst.m0_gnt", m0_gnt, 0);
    check("rst.m1_gnt", m1_gnt, 0);
    check("rst.mem_WE", mem_WE, 0);
    check("rst.mem_A",  mem_A,  0);
    chk_rsp("rst", 0, 0, 0, 0);

    // Release reset. Then run continuous contention: port 0 reads address 1,
    // port 1 reads address 2.
    rst_n = 1'b1;
    drive(1, 0, 1, 0, 1, 0, 2, 0);
    check("rr0.m0_gnt", m0_gnt, 1);
    check("rr0.m1_gnt", m1_gnt, 0);
    check("rr0.mem_A",  mem_A,  1);
    chk_rsp("rr0", 0, 0, 0, 0);
    next_cycle(); #1;
    check("rr1.m1_gnt", m1_gnt, 1);
    check("rr1.m0_gnt", m0_gnt, 0);
    check("rr1.mem_A",  mem_A,  2);
    chk_rsp("rr1", 1, 32'h11, 0, 0);
    next_cycle(); #1;
    check("rr2.m0_gnt", m0_gnt, 1);
    chk_rsp("rr2", 0, 0, 1, 32'h22);
    next_cycle(); #1;
    check("rr3.m1_gnt", m1_gnt, 1);
    chk_rsp("rr3", 1, 32'h11, 0, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("idle.m0_gnt", m0_gnt, 0);
    check("idle.m1_gnt", m1_gnt, 0);
    check("idle.mem_A",  mem_A,  0);
    chk_rsp("idle", 0, 0, 1, 32'h22);

    // Port 0 writes 0xDEADBEEF to address 5. Port 1 then reads it back.
    next_cycle();
    drive(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    check("wr.m0_gnt", m0_gnt, 1);
    check("wr.mem_WE", mem_WE, 1);
    check("wr.mem_A",  mem_A,  5);
    check("wr.mem_WD", mem_WD, 32'hDEADBEEF);
    next_cycle();
    drive(0, 0, 0, 0, 1, 0, 5, 0);
    check("raw.m1_gnt", m1_gnt, 1);
    check("raw.mem_WE", mem_WE, 0);
    chk_rsp("raw.wr_no_rsp", 0, 0, 0, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk_rsp("raw.rsp", 0, 0, 1, 32'hDEADBEEF);

    // Back-to-back port 0 reads of addresses 3, 4 and 5.
    next_cycle();
    drive(1, 0, 3, 0, 0, 0, 0, 0);
    check("b2b.gnt3", m0_gnt, 1);
    next_cycle();
    drive(1, 0, 4, 0, 0, 0, 0, 0);
    check("b2b.gnt4", m0_gnt, 1);
    chk_rsp("b2b.r3", 1, 32'h33, 0, 0);
    next_cycle();
    drive(1, 0, 5, 0, 0, 0, 0, 0);
    chk_rsp("b2b.r4", 1, 32'h44, 0, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk_rsp("b2b.r5", 1, 32'hDEADBEEF, 0, 0);
    next_cycle(); #1;
    chk_rsp("b2b.end", 0, 0, 0, 0);

    // Reset is asserted in the cycle after a read grant. The response is dropped.
    next_cycle();
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    check("rstrd.gnt", m0_gnt, 1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk_rsp("rstrd.in_rst", 0, 0, 0, 0);
    next_cycle();
    rst_n = 1'b1;
    #1;
    chk_rsp("rstrd.rel", 0, 0, 0, 0);
    next_cycle(); #1;
    chk_rsp("rstrd.rel1", 0, 0, 0, 0);

    // Both ports are held requesting for 4 cycles. Port 0 wins the first tie
    // in both builds. After that the grants alternate under round-robin, or
    // stay on port 0 under fixed priority.
    for (int i = 0; i < 4; i++) begin
      logic exp0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      exp0 = 1'b1;
`else
      exp0 = (i % 2 == 0);
`endif
      if (i == 0) drive(1, 0, 1, 0, 1, 0, 2, 0);
      else #1;
      check($sformatf("tie%0d.m0_gnt", i), m0_gnt, exp0);
      check($sformatf("tie%0d.m1_gnt", i), m1_gnt, !exp0);
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
